// File: rtl/mure_pkg.sv
// Shared trace types: widths, the reconstructed per-instruction FIFO entry and
// the expander walker states.
package mure_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned IRETIRE_LEN = 8;
   localparam int unsigned ITYPE_LEN   = 3;
   localparam int unsigned CAUSE_LEN   = 5;
   localparam int unsigned PRIV_LEN    = 2;

   typedef struct packed {
      logic                 valid;
      logic [XLEN-1:0]      pc;
      logic                 compressed;
      logic                 last;
      logic [ITYPE_LEN-1:0] itype;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
      logic [PRIV_LEN-1:0]  priv;
   } fifo_entry_s;

   typedef enum logic [1:0] {
      EXP_IDLE,
      EXP_LOOKUP,
      EXP_EMIT
   } exp_state_e;

endpackage

// File: rtl/ingress_expander.sv
// Re-expands one ingress block into one fifo_entry_s per retired instruction,
// walking the block with an external instruction-size lookup.
module ingress_expander
   import mure_pkg::*;
#(
   parameter bit CHECK_LASTSIZE = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [XLEN-1:0]      iaddr_i,
   input  logic [IRETIRE_LEN-1:0] iretire_i,
   input  logic                 ilastsize_i,
   input  logic [ITYPE_LEN-1:0] itype_i,
   input  logic [CAUSE_LEN-1:0] cause_i,
   input  logic [XLEN-1:0]      tval_i,
   input  logic [PRIV_LEN-1:0]  priv_i,
   output logic                 imem_req_o,
   output logic [XLEN-1:0]      imem_addr_o,
   input  logic                 imem_rvalid_i,
   input  logic                 imem_compressed_i,
   output fifo_entry_s          fifo_entry_o,
   input  logic                 out_ready_i,
   output logic                 err_o
);

   exp_state_e             state_q;
   logic [XLEN-1:0]        pc_q;
   logic [IRETIRE_LEN-1:0] remaining_q;
   logic                   lastsize_q;
   logic [ITYPE_LEN-1:0]   itype_q;
   logic [CAUSE_LEN-1:0]   cause_q;
   logic [XLEN-1:0]        tval_q;
   logic [PRIV_LEN-1:0]    priv_q;
   fifo_entry_s            entry_q;
   logic                   ready_q;
   logic                   req_q;
   logic [XLEN-1:0]        addr_q;
   logic                   err_q;

   logic [IRETIRE_LEN-1:0] size_lookup;
   logic [IRETIRE_LEN-1:0] size_emit;
   logic                   last_lookup;
   logic [XLEN-1:0]        pc_next;

   // Sizes are in halfwords; the emitted entry's size comes from its own
   // compressed flag so the lookup response need not be held during EMIT.
   always_comb begin
      size_lookup = imem_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
      size_emit   = entry_q.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
      last_lookup = (remaining_q == size_lookup);
      pc_next     = pc_q + (entry_q.compressed ? XLEN'(2) : XLEN'(4));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= EXP_IDLE;
         pc_q        <= '0;
         remaining_q <= '0;
         lastsize_q  <= 1'b0;
         itype_q     <= '0;
         cause_q     <= '0;
         tval_q      <= '0;
         priv_q      <= '0;
         entry_q     <= '0;
         ready_q     <= 1'b1;
         req_q       <= 1'b0;
         addr_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            EXP_IDLE: begin
               if (valid_i) begin
                  pc_q        <= iaddr_i;
                  remaining_q <= iretire_i;
                  lastsize_q  <= ilastsize_i;
                  itype_q     <= itype_i;
                  cause_q     <= cause_i;
                  tval_q      <= tval_i;
                  priv_q      <= priv_i;
                  if (iretire_i == '0) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q <= EXP_LOOKUP;
                     ready_q <= 1'b0;
                     req_q   <= 1'b1;
                     addr_q  <= iaddr_i;
                  end
               end
            end
            EXP_LOOKUP: begin
               if (imem_rvalid_i) begin
                  req_q  <= 1'b0;
                  addr_q <= '0;
                  if (size_lookup > remaining_q) begin
                     err_q   <= 1'b1;
                     state_q <= EXP_IDLE;
                     ready_q <= 1'b1;
                  end else begin
                     entry_q.valid      <= 1'b1;
                     entry_q.pc         <= pc_q;
                     entry_q.compressed <= imem_compressed_i;
                     entry_q.last       <= last_lookup;
                     entry_q.itype      <= last_lookup ? itype_q : '0;
                     entry_q.cause      <= last_lookup ? cause_q : '0;
                     entry_q.tval       <= last_lookup ? tval_q : '0;
                     entry_q.priv       <= last_lookup ? priv_q : '0;
                     if (CHECK_LASTSIZE && last_lookup && (!imem_compressed_i != lastsize_q))
                        err_q <= 1'b1;
                     state_q <= EXP_EMIT;
                  end
               end
            end
            EXP_EMIT: begin
               if (out_ready_i) begin
                  pc_q        <= pc_next;
                  remaining_q <= remaining_q - size_emit;
                  entry_q     <= '0;
                  if (entry_q.last) begin
                     state_q <= EXP_IDLE;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= EXP_LOOKUP;
                     req_q   <= 1'b1;
                     addr_q  <= pc_next;
                  end
               end
            end
            default: begin
               state_q <= EXP_IDLE;
               ready_q <= 1'b1;
               req_q   <= 1'b0;
               addr_q  <= '0;
               entry_q <= '0;
            end
         endcase
      end
   end

   assign ready_o      = ready_q;
   assign imem_req_o   = req_q;
   assign imem_addr_o  = addr_q;
   assign fifo_entry_o = entry_q;
   assign err_o        = err_q;

endmodule

// File: doc/ingress_expander.md
Name: ingress_expander

Overview:
- Inverse of the ingress FSM: consumes one ingress block per handshake and re-emits one `mure_pkg::fifo_entry_s` per retired instruction.
- A block is {iaddr, iretire, ilastsize, itype, cause, tval, priv}.
- Instruction sizes come from an external size-lookup port, typically a program-image model or I-mem tap.
- Used on the trace-decoder side and as a reference model in ingress-FSM benches.

Parameters:
- CHECK_LASTSIZE, 1, when 1 a last-instruction size disagreeing with ilastsize raises err_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  ingress block valid
- ready_o  out  1  block accepted when valid_i && ready_o
- iaddr_i  in  XLEN  address of first instruction in block
- iretire_i  in  IRETIRE_LEN  block length in halfwords
- ilastsize_i  in  1  last instruction is 32-bit
- itype_i  in  ITYPE_LEN  block-terminating type
- cause_i  in  CAUSE_LEN  exception cause
- tval_i  in  XLEN  trap value
- priv_i  in  PRIV_LEN  privilege level
- imem_req_o  out  1  size lookup request, held until imem_rvalid_i
- imem_addr_o  out  XLEN  lookup address (current pc)
- imem_rvalid_i  in  1  lookup response valid; may assert in the same cycle as the request
- imem_compressed_i  in  1  1 = 16-bit instruction at imem_addr_o
- fifo_entry_o  out  fifo_entry_s  reconstructed instruction; .valid is the output valid
- out_ready_i  in  1  downstream accepts fifo_entry_o
- err_o  out  1  single-cycle protocol error pulse

Behaviour:
- Reset (async, rst_i=1):
  - State is IDLE.
  - All registers clear: pc_q, remaining_q, block fields.
  - Outputs: ready_o=1, imem_req_o=0, imem_addr_o=0, fifo_entry_o all-zero, err_o=0.
  - Reset mid-block drops the block; no partial output.
- IDLE:
  - ready_o=1; all other outputs idle.
  - On accept: pc_q=iaddr_i, remaining_q=iretire_i, latch ilastsize/itype/cause/tval/priv.
  - iretire_i==0: err_o pulses next cycle, block dropped, stay IDLE.
  - Otherwise go to LOOKUP.
  - imem_rvalid_i is ignored in IDLE.
- LOOKUP:
  - ready_o=0, imem_req_o=1, imem_addr_o=pc_q.
  - On imem_rvalid_i: size = imem_compressed_i ? 1 : 2 halfwords.
  - If size > remaining_q: err_o pulses, block dropped, go to IDLE.
  - Else latch the entry:
    - pc = pc_q; compressed = imem_compressed_i; last = (remaining_q == size).
    - itype = last ? itype_q : 0.
    - cause/tval/priv = last ? latched values : 0.
  - If last && CHECK_LASTSIZE && (!imem_compressed_i != ilastsize_q): err_o pulses, entry still emitted.
  - Go to EMIT.
- EMIT:
  - fifo_entry_o.valid=1; the entry is held stable while out_ready_i=0.
  - On out_ready_i:
    - pc_q += 2*size; remaining_q -= size.
    - Last entry: go to IDLE, so ready_o=1 the next cycle.
    - Otherwise: go to LOOKUP.
- Latency:
  - With a same-cycle imem response and out_ready_i=1, one instruction is emitted every 2 cycles.
  - The first entry is valid 2 cycles after block accept.
- Arithmetic:
  - pc wraps modulo 2^XLEN.
  - remaining_q is IRETIRE_LEN wide and never underflows, guaranteed by the size>remaining check.
- Error pulses are exactly one cycle, registered. err_o never blocks the next block accept.
- No block pipelining: a new block is accepted only in IDLE.

Decomposition:
- mure_pkg: add `exp_state_e {EXP_IDLE, EXP_LOOKUP, EXP_EMIT}`.
- Reuse fifo_entry_s, XLEN, IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, PRIV_LEN unchanged.
- Single module, no sub-module. The block register and the walker FSM are too tightly coupled to split.

Test Plan:
- All compressed, 4-halfword block:
  - Stimulus: iaddr=0x8000_0000, iretire=4, ilastsize=0, itype=2; lookups all compressed; out_ready=1.
  - Response: 4 entries at pc 0x8000_0000/02/04/06. itype=0,0,0,2. Last entry cause/tval/priv match the block. err_o=0.
- Mixed sizes:
  - Stimulus: iretire=5, lookups 32/16/32 bits, ilastsize=1, itype=1, cause=2, tval=0xDEAD.
  - Response: pcs base/+4/+6. Only the third entry has itype=1, cause=2, tval=0xDEAD.
- Size overrun:
  - Stimulus: iretire=3, lookups 32/32 bits.
  - Response: first entry emitted; second lookup pulses err_o; return to IDLE with no second entry.
- Backpressure and delayed lookup:
  - Stimulus: out_ready_i=0 for 5 cycles; imem_rvalid_i 3 cycles after req.
  - Response: imem_req_o and imem_addr_o held stable until rvalid; entry held stable until accept.
- Zero length and lastsize mismatch:
  - Stimulus: iretire=0.
  - Response: err_o pulse, no output.
  - Stimulus: iretire=1 (compressed) with ilastsize=1.
  - Response: entry emitted and err_o pulses.
- Reset mid-block:
  - Stimulus: assert rst_i during EMIT of entry 2 of 4.
  - Response: outputs zero immediately (async), ready_o=1. A fresh block afterwards starts from its own iaddr.
